// File: rtl/mac_pkg.sv
// Shared MAC field layout and decoded-element type.
package mac_pkg;
  localparam int ACT_W    = 16;
  localparam int EXP_W    = 6;
  localparam int FRAC_W   = 9;
  localparam int MANT_W   = 10;
  localparam int SGN_BIT  = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 9;
  localparam int FRAC_MSB = 8;
  localparam int FRAC_LSB = 0;

  typedef struct packed {
    logic              sgn;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              zero;
  } elem_t;
endpackage

// File: rtl/act_unpack.sv
// Combinational activation decode; zero latency, no flow control.
// MAC_STG0_FTZ_EN flushes subnormals to zero, otherwise they decode with exponent 1.
module act_unpack
  import mac_pkg::*;
(
  input  logic [ACT_W-1:0] act,
  output elem_t            dec
);
  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;

  assign exp_f  = act[EXP_MSB:EXP_LSB];
  assign frac_f = act[FRAC_MSB:FRAC_LSB];

  always_comb begin
    dec = '0;
    if (exp_f != '0) begin
      dec.sgn  = act[SGN_BIT];
      dec.exp  = exp_f;
      dec.mant = {1'b1, frac_f};
    end else if (frac_f == '0) begin
      // Signed zero collapses to +0 with all fields cleared.
      dec.zero = 1'b1;
    end else begin
`ifdef MAC_STG0_FTZ_EN
      dec.zero = 1'b1;
`else
      dec.sgn  = act[SGN_BIT];
      dec.exp  = {{(EXP_W-1){1'b0}}, 1'b1};
      dec.mant = {1'b0, frac_f};
`endif
    end
  end
endmodule

// File: rtl/mac_stg0.sv
// MAC stage 0: registered decode plus group counting and running max exponent; 1-cycle latency.
// i_inhibit freezes every register; subnormal handling set by MAC_STG0_FTZ_EN.
module mac_stg0
  import mac_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_inhibit,
  input  logic                i_valid,
  input  logic [ACT_W-1:0]    i_act,
  input  logic [CNT_W-1:0]    i_grp_len,
  output logic                o_valid,
  output logic                o_sgn,
  output logic [EXP_W-1:0]    o_exp,
  output logic [MANT_W-1:0]   o_mant,
  output logic                o_zero,
  output logic                o_grp_last,
  output logic [EXP_W-1:0]    o_grp_max_exp,
  output logic [50:0]         o_transistor_num
);
  localparam logic [CNT_W:0] LEN_MAX = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

  elem_t            dec;
  logic             acc;
  logic             grp_start;
  logic             grp_last;
  logic [CNT_W:0]   cnt_q;
  logic [CNT_W:0]   cnt_nxt;
  logic [CNT_W:0]   len_q;
  logic [CNT_W:0]   len_eff;
  logic [EXP_W-1:0] max_q;
  logic [EXP_W-1:0] max_base;
  logic [EXP_W-1:0] max_nxt;

  act_unpack u_act_unpack (
    .act (i_act),
    .dec (dec)
  );

  assign acc       = i_valid & ~i_inhibit;
  assign grp_start = (cnt_q == '0);

  // Group length is captured on the first element; 0 encodes the full 2^CNT_W window.
  assign len_eff  = !grp_start ? len_q :
                    (i_grp_len == '0) ? LEN_MAX : {1'b0, i_grp_len};
  assign cnt_nxt  = cnt_q + CNT_ONE;
  assign grp_last = (cnt_nxt == len_eff);
  assign max_base = grp_start ? '0 : max_q;
  assign max_nxt  = (dec.exp > max_base) ? dec.exp : max_base;

  assign o_transistor_num = '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid       <= 1'b0;
      o_sgn         <= 1'b0;
      o_exp         <= '0;
      o_mant        <= '0;
      o_zero        <= 1'b0;
      o_grp_last    <= 1'b0;
      o_grp_max_exp <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      max_q         <= '0;
    end else if (acc) begin
      o_valid       <= 1'b1;
      o_sgn         <= dec.sgn;
      o_exp         <= dec.exp;
      o_mant        <= dec.mant;
      o_zero        <= dec.zero;
      o_grp_last    <= grp_last;
      o_grp_max_exp <= max_nxt;
      len_q         <= len_eff;
      cnt_q         <= grp_last ? '0 : cnt_nxt;
      max_q         <= grp_last ? '0 : max_nxt;
    end else if (!i_inhibit) begin
      o_valid       <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mac_stg0.sv
// Scoreboard bench for mac_stg0: expected elements queued at drive time, compared on output.
module tb_mac_stg0;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic       sgn;
    logic [5:0] exp;
    logic [9:0] mant;
    logic       zero;
    logic       last;
    logic [5:0] mx;
  } exp_t;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_inhibit;
  logic             i_valid;
  logic [15:0]      i_act;
  logic [CNT_W-1:0] i_grp_len;
  logic             o_valid;
  logic             o_sgn;
  logic [5:0]       o_exp;
  logic [9:0]       o_mant;
  logic             o_zero;
  logic             o_grp_last;
  logic [5:0]       o_grp_max_exp;
  logic [50:0]      o_transistor_num;

  always #5 i_clk = ~i_clk;

  mac_stg0 #(.CNT_W(CNT_W)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_inhibit        (i_inhibit),
    .i_valid          (i_valid),
    .i_act            (i_act),
    .i_grp_len        (i_grp_len),
    .o_valid          (o_valid),
    .o_sgn            (o_sgn),
    .o_exp            (o_exp),
    .o_mant           (o_mant),
    .o_zero           (o_zero),
    .o_grp_last       (o_grp_last),
    .o_grp_max_exp    (o_grp_max_exp),
    .o_transistor_num (o_transistor_num)
  );

  int   n_chk = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t last_e;
  logic exp_vld;
  int   m_cnt;
  int   m_len;
  int   m_max;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  function automatic logic [15:0] mk(input logic s, input logic [5:0] e, input logic [8:0] f);
    logic [15:0] w;
    w = {s, e, f};
    return w;
  endfunction

  function automatic exp_t decode(input logic [15:0] a);
    exp_t       e;
    logic [5:0] ex;
    logic [8:0] fr;
    e  = '0;
    ex = a[14:9];
    fr = a[8:0];
    if (ex != 0) begin
      e.sgn = a[15]; e.exp = ex; e.mant = {1'b1, fr};
    end else if (fr == 0) begin
      e.zero = 1'b1;
    end else begin
`ifdef MAC_STG0_FTZ_EN
      e.zero = 1'b1;
`else
      e.sgn = a[15]; e.exp = 6'd1; e.mant = {1'b0, fr};
`endif
    end
    return e;
  endfunction

  task automatic cmp_fields(input string tag, input exp_t e);
    chk({tag, ".sgn"},  o_sgn,         e.sgn);
    chk({tag, ".exp"},  o_exp,         e.exp);
    chk({tag, ".mant"}, o_mant,        e.mant);
    chk({tag, ".zero"}, o_zero,        e.zero);
    chk({tag, ".last"}, o_grp_last,    e.last);
    chk({tag, ".max"},  o_grp_max_exp, e.mx);
  endtask

  // One clock: drive, update the model at the edge, check at the following negedge.
  task automatic step(input logic v, input logic [15:0] a, input logic [CNT_W-1:0] len, input logic inh);
    exp_t e;
    i_valid = v; i_act = a; i_grp_len = len; i_inhibit = inh;
    @(posedge i_clk);
    if (!inh) begin
      if (v) begin
        e = decode(a);
        if (m_cnt == 0) begin
          m_len = (len == 0) ? (1 << CNT_W) : int'(len);
          m_max = 0;
        end
        m_cnt++;
        if (int'(e.exp) > m_max) m_max = int'(e.exp);
        e.mx   = m_max[5:0];
        e.last = (m_cnt == m_len);
        if (e.last) begin m_cnt = 0; m_max = 0; end
        sb.push_back(e);
      end
      exp_vld = v;
    end
    @(negedge i_clk);
    chk("o_valid", o_valid, exp_vld);
    if (inh) begin
      cmp_fields("hold", last_e);
    end else if (exp_vld) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        cmp_fields("elem", e);
        last_e = e;
      end
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #2;
    chk("rst.valid", o_valid, 0);
    chk("rst.fields", {o_sgn, o_exp, o_mant, o_zero}, 0);
    chk("rst.last", o_grp_last, 0);
    chk("rst.max", o_grp_max_exp, 0);
    m_cnt = 0; m_max = 0; m_len = 0;
    exp_vld = 1'b0;
    last_e = '0;
    sb.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_inhibit = 1'b0; i_valid = 1'b0; i_act = '0; i_grp_len = '0;
    do_reset();
    chk("xtor", o_transistor_num, 0);

    // Single known decode
    step(1, 16'h3A05, 4'd1, 0);
    chk("t34.exp", o_exp, 6'h1D);
    chk("t34.mant", o_mant, 10'h205);
    chk("t34.last", o_grp_last, 1);
    step(0, 16'h0, 4'd1, 0);

    // Group of 3; later i_grp_len changes must be ignored mid-group
    step(1, mk(0, 6'd5, 9'h011), 4'd3, 0);
    step(1, mk(1, 6'd12, 9'h0F0), 4'd1, 0);
    chk("t35.notlast", o_grp_last, 0);
    step(1, mk(0, 6'd7, 9'h1AA), 4'd1, 0);
    chk("t35.last", o_grp_last, 1);
    chk("t35.max", o_grp_max_exp, 6'd12);
    step(1, mk(0, 6'd2, 9'h003), 4'd3, 0);
    chk("t35.next", o_grp_max_exp, 6'd2);
    step(1, mk(0, 6'd1, 9'h000), 4'd3, 0);
    step(1, mk(0, 6'd1, 9'h000), 4'd3, 0);

    // Inhibit mid-group with valid high and changing data
    step(1, mk(0, 6'd20, 9'h001), 4'd5, 0);
    step(1, mk(0, 6'd10, 9'h002), 4'd5, 0);
    for (int i = 0; i < 4; i++) step(1, mk(0, 6'(40 + i), 9'(i)), 4'd1, 1);
    step(1, mk(0, 6'd3, 9'h004), 4'd1, 0);
    step(0, 16'h0, 4'd1, 0);
    step(1, mk(0, 6'd30, 9'h005), 4'd1, 0);
    chk("t36.mid", o_grp_last, 0);
    step(1, mk(0, 6'd4, 9'h006), 4'd1, 0);
    chk("t36.last", o_grp_last, 1);
    chk("t36.max", o_grp_max_exp, 6'd30);

    // Negative zero leaves running max untouched
    step(1, mk(0, 6'd9, 9'h000), 4'd3, 0);
    step(1, 16'h8000, 4'd3, 0);
    chk("t37.zero", o_zero, 1);
    chk("t37.sgn", o_sgn, 0);
    chk("t37.max", o_grp_max_exp, 6'd9);
    step(1, mk(0, 6'd4, 9'h000), 4'd3, 0);

    // Subnormal
    step(1, 16'h0003, 4'd2, 0);
`ifdef MAC_STG0_FTZ_EN
    chk("t38.zero", o_zero, 1);
`else
    chk("t38.exp", o_exp, 6'd1);
    chk("t38.mant", o_mant, 10'h003);
`endif
    step(1, mk(1, 6'h3F, 9'h1FF), 4'd2, 0);

    // Reset after 2 of 9, then a fresh 9-element group
    step(1, mk(0, 6'd11, 9'h0), 4'd9, 0);
    step(1, mk(0, 6'd12, 9'h0), 4'd9, 0);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, mk(0, 6'(i + 1), 9'(i)), 4'd9, 0);
      chk("t39.last", o_grp_last, (i == 8));
    end

    // Length 0 means a full 16-element window
    for (int i = 0; i < 16; i++) begin
      step(1, 16'($urandom), 4'd0, 0);
      chk("len0.last", o_grp_last, (i == 15));
    end

    // Random traffic with idles and stalls
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 4) == 0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/mac_stg0.md
MAC_STG0 -- requirements
Module: mac_stg0

Interface
REQ-001 SHALL have parameter CNT_W, default 4: group counter width; maximum group length is 2^CNT_W.
REQ-002 SHALL have port i_clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port i_rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port i_inhibit, input, 1: pipeline stall; freezes all state.
REQ-005 SHALL have port i_valid, input, 1: i_act carries an element this cycle.
REQ-006 SHALL have port i_act, input, 16: activation word; [15] sign, [14:9] exponent, [8:0] fraction.
REQ-007 SHALL have port i_grp_len, input, CNT_W: elements per group (kernel window); 0 means 2^CNT_W.
REQ-008 SHALL have port o_valid, output, 1: decoded element valid.
REQ-009 SHALL have port o_sgn, output, 1: element sign.
REQ-010 SHALL have port o_exp, output, 6: element exponent.
REQ-011 SHALL have port o_mant, output, 10: mantissa with hidden bit at [9].
REQ-012 SHALL have port o_zero, output, 1: element is zero.
REQ-013 SHALL have port o_grp_last, output, 1: element is last of its group.
REQ-014 SHALL have port o_grp_max_exp, output, 6: running group maximum exponent, including the current element.
REQ-015 SHALL have port o_transistor_num, output, 51: tied to 0.

Function
REQ-016 SHALL register decoded fields with 1-cycle latency: an element accepted at edge N appears on the outputs after edge N.
REQ-017 SHALL define acceptance as i_valid=1 and i_inhibit=0 at a rising edge.
REQ-018 While i_inhibit=1, SHALL hold every register, including outputs, counter and running max, and SHALL ignore i_valid and i_act.
REQ-019 SHALL drive o_valid=0 after an edge with i_valid=0 and i_inhibit=0; counter and running max SHALL remain unchanged.
REQ-020 SHALL set o_mant = {1'b1, frac} when exp != 0.
REQ-021 SHALL set o_zero=1 when exp=0 and frac=0; o_exp, o_mant and o_sgn SHALL then be 0.
REQ-022 SHALL sample i_grp_len on the first accepted element of each group and hold it until that group completes.
REQ-023 SHALL count accepted elements; the element whose count equals the latched length SHALL output o_grp_last=1, after which the counter and running max SHALL clear for the next group.
REQ-024 SHALL update the running max as max(previous, element exponent); zero elements SHALL contribute 0.
REQ-025 SHALL register o_grp_max_exp with the same element it includes; it is authoritative when o_grp_last=1.
REQ-026 With a group length of 1, every accepted element SHALL assert o_grp_last, and o_grp_max_exp SHALL equal that element's exponent.
REQ-027 SHALL let the counter wrap only via group completion; it SHALL never exceed the latched length.

Reset
REQ-028 On i_rst_n=0, SHALL asynchronously clear all registers: o_valid, o_sgn, o_exp, o_mant, o_zero, o_grp_last and o_grp_max_exp all 0; counter 0; latched length 0.
REQ-029 Reset mid-group SHALL discard the partial group; the first accepted element after release SHALL start a new group.

Configuration
REQ-030 With MAC_STG0_FTZ_EN defined, SHALL treat exp=0 with frac!=0 (subnormal) as zero: o_zero=1, fields 0.
REQ-031 Without MAC_STG0_FTZ_EN, SHALL decode a subnormal as o_exp=1, o_mant={1'b0, frac}, o_zero=0, and SHALL use exponent 1 in the running max.

Structure
REQ-032 SHALL place the field widths (EXP_W=6, FRAC_W=9, MANT_W=10, ACT_W=16) and the field bit positions in the shared MAC package, which the other MAC stages use.
REQ-033 SHALL implement decode in one combinational sub-module, act_unpack, that produces sgn, exp, mant and zero; the sequential logic stays in mac_stg0.

Verification
REQ-034 Accept i_act=16'h3A05 -> next cycle o_valid=1, o_sgn=0, o_exp=6'h1D, o_mant=10'h205, o_zero=0.
REQ-035 i_grp_len=3, accept exponents 5, 12, 7 on consecutive cycles -> o_grp_last=1 on the third output only, with o_grp_max_exp=12; the next group's first output shows its own exponent.
REQ-036 Assert i_inhibit for 4 cycles in mid-group, with i_valid=1 and changing i_act -> outputs frozen; the group completes after exactly the remaining accepted elements.
REQ-037 i_act=16'h8000 (negative zero) -> o_zero=1, o_sgn=0, o_exp=0; the running max is unchanged.
REQ-038 i_act=16'h0003: with MAC_STG0_FTZ_EN -> o_zero=1; without it -> o_exp=1, o_mant=10'h003.
REQ-039 Pulse i_rst_n low after 2 of 9 elements -> all outputs 0; the next 9 accepted elements form one complete group, with o_grp_last on the 9th.
